// File: rtl/unidade_load_store_if.sv
// Request/response and data-memory bus of unidade_load_store.
// slave: the load/store unit; master: the datapath and the data memory together.
interface unidade_load_store_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  req_valido;
    logic                  req_escrita;
    logic [1:0]            req_tamanho;
    logic                  req_sinal;
    logic [ADDR_WIDTH-1:0] req_endereco;
    logic [DATA_WIDTH-1:0] req_dados;
    logic                  req_pronto;
    logic                  resp_valido;
    logic [DATA_WIDTH-1:0] resp_dados;
    logic                  erro_alinhamento;
    logic [ADDR_WIDTH-1:0] mem_endereco;
    logic                  mem_LeMem;
    logic                  mem_EscreveMem;
    logic [DATA_WIDTH-1:0] mem_Dados_escrita;
    logic [DATA_WIDTH-1:0] mem_Dados_leitura;

    modport slave (
        input  req_valido, req_escrita, req_tamanho, req_sinal, req_endereco, req_dados,
        input  mem_Dados_leitura,
        output req_pronto, resp_valido, resp_dados, erro_alinhamento,
        output mem_endereco, mem_LeMem, mem_EscreveMem, mem_Dados_escrita
    );

    modport master (
        output req_valido, req_escrita, req_tamanho, req_sinal, req_endereco, req_dados,
        output mem_Dados_leitura,
        input  req_pronto, resp_valido, resp_dados, erro_alinhamento,
        input  mem_endereco, mem_LeMem, mem_EscreveMem, mem_Dados_escrita
    );
endinterface

// File: rtl/unidade_load_store.sv
// Load/store initiator: byte/half/word access to a word-only data memory, sub-word stores by RMW.
// Optional access counters enabled with `define LS_CONTADORES_EN.
module unidade_load_store #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    unidade_load_store_if.slave    bus,
    output logic [31:0]            cont_leituras,
    output logic [31:0]            cont_escritas
);
    localparam int unsigned OFF_W  = 2;
    localparam int unsigned WORD_W = ADDR_WIDTH - OFF_W;

    localparam logic [1:0] TAM_BYTE = 2'b00;
    localparam logic [1:0] TAM_HALF = 2'b01;
    localparam logic [1:0] TAM_WORD = 2'b10;

    typedef enum logic [1:0] {OCIOSO, LER, CAPTURA, ESCREVER} estado_t;

    estado_t                estado_q, estado_n;
    logic                   pronto_q, pronto_n;
    logic                   resp_valido_q, resp_valido_n;
    logic                   erro_q, erro_n;
    logic                   le_q, le_n;
    logic                   es_q, es_n;
    logic [ADDR_WIDTH-1:0]  end_q, end_n;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_n;
    logic [DATA_WIDTH-1:0]  resp_dados_q, resp_dados_n;

    // Request fields latched at acceptance
    logic                   escrita_q;
    logic [1:0]             tam_q;
    logic                   sinal_q;
    logic [OFF_W-1:0]       off_q;
    logic [15:0]            dados_q;

    logic                   alinhado_c;
    logic                   aceita_c;
    logic [7:0]             byte_c;
    logic [15:0]            half_c;
    logic [DATA_WIDTH-1:0]  ext_c;
    logic [DATA_WIDTH-1:0]  merge_c;

    always_comb begin
        alinhado_c = 1'b0;
        case (bus.req_tamanho)
            TAM_BYTE: alinhado_c = 1'b1;
            TAM_HALF: alinhado_c = ~bus.req_endereco[0];
            TAM_WORD: alinhado_c = (bus.req_endereco[1:0] == 2'b00);
            default:  alinhado_c = 1'b0;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores (little-endian)
    always_comb begin
        byte_c  = 8'h00;
        half_c  = off_q[1] ? bus.mem_Dados_leitura[31:16] : bus.mem_Dados_leitura[15:0];
        merge_c = bus.mem_Dados_leitura;
        case (off_q)
            2'd0: byte_c = bus.mem_Dados_leitura[7:0];
            2'd1: byte_c = bus.mem_Dados_leitura[15:8];
            2'd2: byte_c = bus.mem_Dados_leitura[23:16];
            default: byte_c = bus.mem_Dados_leitura[31:24];
        endcase
        if (tam_q == TAM_BYTE) begin
            case (off_q)
                2'd0: merge_c[7:0]   = dados_q[7:0];
                2'd1: merge_c[15:8]  = dados_q[7:0];
                2'd2: merge_c[23:16] = dados_q[7:0];
                default: merge_c[31:24] = dados_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merge_c[31:16] = dados_q;
        end else begin
            merge_c[15:0] = dados_q;
        end
        case (tam_q)
            TAM_BYTE: ext_c = sinal_q ? {{24{byte_c[7]}}, byte_c} : {24'h000000, byte_c};
            TAM_HALF: ext_c = sinal_q ? {{16{half_c[15]}}, half_c} : {16'h0000, half_c};
            default:  ext_c = bus.mem_Dados_leitura;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_n;
        end
    end

    // Next state plus next value of every registered output
    always_comb begin
        estado_n      = estado_q;
        pronto_n      = 1'b0;
        resp_valido_n = 1'b0;
        erro_n        = 1'b0;
        le_n          = 1'b0;
        es_n          = 1'b0;
        end_n         = end_q;
        wdata_n       = wdata_q;
        resp_dados_n  = resp_dados_q;
        aceita_c      = 1'b0;
        case (estado_q)
            OCIOSO: begin
                pronto_n = 1'b1;
                if (bus.req_valido) begin
                    if (!alinhado_c) begin
                        erro_n = 1'b1;
                    end else begin
                        aceita_c = 1'b1;
                        pronto_n = 1'b0;
                        end_n    = ADDR_WIDTH'(bus.req_endereco[ADDR_WIDTH-1:OFF_W]);
                        if (bus.req_escrita && (bus.req_tamanho == TAM_WORD)) begin
                            estado_n = ESCREVER;
                            es_n     = 1'b1;
                            wdata_n  = bus.req_dados;
                        end else begin
                            estado_n = LER;
                            le_n     = 1'b1;
                        end
                    end
                end
            end
            LER: begin
                estado_n = CAPTURA;
            end
            CAPTURA: begin
                if (escrita_q) begin
                    estado_n = ESCREVER;
                    es_n     = 1'b1;
                    wdata_n  = merge_c;
                end else begin
                    estado_n      = OCIOSO;
                    pronto_n      = 1'b1;
                    resp_valido_n = 1'b1;
                    resp_dados_n  = ext_c;
                end
            end
            ESCREVER: begin
                estado_n = OCIOSO;
                pronto_n = 1'b1;
            end
            default: begin
                estado_n = OCIOSO;
                pronto_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pronto_q      <= 1'b1;
            resp_valido_q <= 1'b0;
            erro_q        <= 1'b0;
            le_q          <= 1'b0;
            es_q          <= 1'b0;
            end_q         <= '0;
            wdata_q       <= '0;
            resp_dados_q  <= '0;
            escrita_q     <= 1'b0;
            tam_q         <= TAM_BYTE;
            sinal_q       <= 1'b0;
            off_q         <= '0;
            dados_q       <= '0;
        end else begin
            pronto_q      <= pronto_n;
            resp_valido_q <= resp_valido_n;
            erro_q        <= erro_n;
            le_q          <= le_n;
            es_q          <= es_n;
            end_q         <= end_n;
            wdata_q       <= wdata_n;
            resp_dados_q  <= resp_dados_n;
            if (aceita_c) begin
                escrita_q <= bus.req_escrita;
                tam_q     <= bus.req_tamanho;
                sinal_q   <= bus.req_sinal;
                off_q     <= bus.req_endereco[OFF_W-1:0];
                dados_q   <= bus.req_dados[15:0];
            end
        end
    end

    assign bus.req_pronto        = pronto_q;
    assign bus.resp_valido       = resp_valido_q;
    assign bus.resp_dados        = resp_dados_q;
    assign bus.erro_alinhamento  = erro_q;
    assign bus.mem_endereco      = end_q;
    assign bus.mem_LeMem         = le_q;
    assign bus.mem_EscreveMem    = es_q;
    assign bus.mem_Dados_escrita = wdata_q;

`ifdef LS_CONTADORES_EN
    // Each count advances in the cycle its strobe is high
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cont_leituras <= '0;
            cont_escritas <= '0;
        end else begin
            if (le_q) cont_leituras <= cont_leituras + 32'd1;
            if (es_q) cont_escritas <= cont_escritas + 32'd1;
        end
    end
`else
    assign cont_leituras = '0;
    assign cont_escritas = '0;
`endif

    logic unused_c;
    assign unused_c = ^{WORD_W};
endmodule

// File: tb/tb_unidade_load_store.sv
// Directed bench for unidade_load_store with a word-memory model and write/response scoreboards.
module tb_unidade_load_store;
    logic        clock;
    logic        reset_n;
    logic [31:0] cont_leituras;
    logic [31:0] cont_escritas;

    unidade_load_store_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    unidade_load_store #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .bus           (bus.slave),
        .cont_leituras (cont_leituras),
        .cont_escritas (cont_escritas)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory: read data valid the cycle after the read strobe
    logic [31:0] mem [0:255];
    logic [31:0] rd_q;
    always @(posedge clock) begin
        if (bus.mem_LeMem) rd_q <= mem[bus.mem_endereco[7:0]];
        if (bus.mem_EscreveMem) mem[bus.mem_endereco[7:0]] <= bus.mem_Dados_escrita;
    end
    assign bus.mem_Dados_leitura = rd_q;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    int l_le, l_es, l_resp, l_erro, l_pronto;
    bit busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample away from the edge, retire scoreboard entries
    task automatic tick();
        logic [63:0] w;
        logic [31:0] r;
        @(posedge clock);
        #1;
        if (bus.mem_LeMem || bus.mem_EscreveMem)
            chk("strobe_exclusive", 64'(bus.mem_LeMem && bus.mem_EscreveMem), 64'd0);
        if (bus.mem_EscreveMem) begin
            chk("write_expected", 64'(exp_wr.size() != 0), 64'd1);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                chk("write", {bus.mem_endereco, bus.mem_Dados_escrita}, w);
            end
        end
        if (bus.resp_valido) begin
            chk("resp_expected", 64'(exp_rd.size() != 0), 64'd1);
            if (exp_rd.size() != 0) begin
                r = exp_rd.pop_front();
                chk("resp_dados", 64'(bus.resp_dados), 64'(r));
            end
        end
    endtask

    // Present one request for one cycle, then watch six cycles for event latencies
    task automatic run_req(input logic w, input logic [1:0] t, input logic s,
                           input logic [31:0] a, input logic [31:0] d);
        bus.req_valido   = 1'b1;
        bus.req_escrita  = w;
        bus.req_tamanho  = t;
        bus.req_sinal    = s;
        bus.req_endereco = a;
        bus.req_dados    = d;
        l_le = -1; l_es = -1; l_resp = -1; l_erro = -1; l_pronto = -1; busy = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) bus.req_valido = 1'b0;
            if (bus.mem_LeMem && l_le < 0) l_le = c;
            if (bus.mem_EscreveMem && l_es < 0) l_es = c;
            if (bus.resp_valido && l_resp < 0) l_resp = c;
            if (bus.erro_alinhamento && l_erro < 0) l_erro = c;
            if (!bus.req_pronto) busy = 1'b1;
            else if (busy && l_pronto < 0) l_pronto = c;
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_wr.push_back({a >> 2, d});
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.req_valido   = 1'b0;
        bus.req_escrita  = 1'b0;
        bus.req_tamanho  = 2'b00;
        bus.req_sinal    = 1'b0;
        bus.req_endereco = '0;
        bus.req_dados    = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_pronto", 64'(bus.req_pronto), 64'd1);
        chk("rst_resp_valido", 64'(bus.resp_valido), 64'd0);
        chk("rst_erro", 64'(bus.erro_alinhamento), 64'd0);
        chk("rst_strobes", 64'({bus.mem_LeMem, bus.mem_EscreveMem}), 64'd0);
        chk("rst_endereco", 64'(bus.mem_endereco), 64'd0);
        chk("rst_wdata", 64'(bus.mem_Dados_escrita), 64'd0);
        chk("rst_resp_dados", 64'(bus.resp_dados), 64'd0);
        chk("rst_contadores", {cont_leituras, cont_escritas}, 64'd0);
        reset_n = 1'b1;
        tick();

        // Word store then word load
        push_wr(32'h10, 32'hDEADBEEF);
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        chk_i("wst_lat_es", l_es, 1);
        chk_i("wst_lat_pronto", l_pronto, 2);
        chk_i("wst_no_read", l_le, -1);
        exp_rd.push_back(32'hDEADBEEF);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk_i("wld_lat_le", l_le, 1);
        chk_i("wld_lat_resp", l_resp, 3);
        chk_i("wld_lat_pronto", l_pronto, 3);
        chk("wld_resp_hold", 64'(bus.resp_dados), 64'hDEADBEEF);

        // Byte store by read-modify-write
        push_wr(32'h20, 32'h11223344);
        run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
        push_wr(32'h20, 32'h11AA3344);
        run_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA);
        chk_i("bst_lat_le", l_le, 1);
        chk_i("bst_lat_es", l_es, 3);
        chk_i("bst_lat_pronto", l_pronto, 4);

        // Sub-word loads with sign/zero extension
        push_wr(32'h30, 32'h8000F0FF);
        run_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h8000F0FF);
        exp_rd.push_back(32'hFFFFFFFF);
        run_req(1'b0, 2'b00, 1'b1, 32'h30, 32'h0);
        exp_rd.push_back(32'h000000FF);
        run_req(1'b0, 2'b00, 1'b0, 32'h30, 32'h0);
        exp_rd.push_back(32'hFFFF8000);
        run_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0);
        exp_rd.push_back(32'h00008000);
        run_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
        exp_rd.push_back(32'h0000F0FF);
        run_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0);
        exp_rd.push_back(32'hFFFFFF80);
        run_req(1'b0, 2'b00, 1'b1, 32'h33, 32'h0);
        chk_i("sld_lat_resp", l_resp, 3);

        // Misaligned and reserved-size requests
        run_req(1'b1, 2'b01, 1'b0, 32'h41, 32'h1234);
        chk_i("mis_half_erro", l_erro, 1);
        chk_i("mis_half_strobes", l_le + l_es, -2);
        chk("mis_half_busy", 64'(busy), 64'd0);
        run_req(1'b0, 2'b10, 1'b0, 32'h42, 32'h0);
        chk_i("mis_word_erro", l_erro, 1);
        chk_i("mis_word_strobes", l_le + l_es, -2);
        chk("mis_word_busy", 64'(busy), 64'd0);
        run_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
        chk_i("mis_res_erro", l_erro, 1);
        chk_i("mis_res_strobes", l_le + l_es, -2);
        chk("mis_res_busy", 64'(busy), 64'd0);

        // Reset during CAPTURA of a byte store aborts it
        push_wr(32'h50, 32'h55667788);
        run_req(1'b1, 2'b10, 1'b0, 32'h50, 32'h55667788);
        bus.req_valido   = 1'b1;
        bus.req_escrita  = 1'b1;
        bus.req_tamanho  = 2'b00;
        bus.req_endereco = 32'h51;
        bus.req_dados    = 32'h99;
        tick();
        bus.req_valido = 1'b0;
        chk("abt_le_c1", 64'(bus.mem_LeMem), 64'd1);
        tick();
        chk("abt_capt_pronto", 64'(bus.req_pronto), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abt_strobes", 64'({bus.mem_LeMem, bus.mem_EscreveMem}), 64'd0);
        chk("abt_pronto", 64'(bus.req_pronto), 64'd1);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("abt_no_resp", 64'(bus.resp_valido), 64'd0);
        exp_rd.push_back(32'h55667788);
        run_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
        chk_i("abt_readback_lat", l_resp, 3);

        // Counter totals since reset: 2 loads, 1 word store, 1 byte store
        push_wr(32'h60, 32'hCAFEBABE);
        run_req(1'b1, 2'b10, 1'b0, 32'h60, 32'hCAFEBABE);
        push_wr(32'h60, 32'hCAFE5ABE);
        run_req(1'b1, 2'b00, 1'b0, 32'h61, 32'h5A);
        exp_rd.push_back(32'hCAFE5ABE);
        run_req(1'b0, 2'b10, 1'b0, 32'h60, 32'h0);
`ifdef LS_CONTADORES_EN
        chk("cont_leituras", 64'(cont_leituras), 64'd3);
        chk("cont_escritas", 64'(cont_escritas), 64'd2);
`else
        chk("cont_leituras", 64'(cont_leituras), 64'd0);
        chk("cont_escritas", 64'(cont_escritas), 64'd0);
`endif

        chk_i("wr_queue_drained", exp_wr.size(), 0);
        chk_i("rd_queue_drained", exp_rd.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/unidade_load_store.md
Name: unidade_load_store

Overview:
- Initiator side of the data-memory interface. Accepts load/store requests from the datapath and drives the data memory's word address, read strobe, write strobe and write data.
- Adds byte/halfword access on top of the word-only memory: sign/zero-extended sub-word loads, and sub-word stores by read-modify-write.
- Sits between the EX/MEM stage and the data memory. One request in flight at a time.

Parameters:
- ADDR_WIDTH, 32, width of byte address from datapath; memory word address = byte address >> 2.
- DATA_WIDTH, 32, data word width; fixed at 32, other values unsupported.

Ports:
- clock  in  1  single system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valido  in  1  request present; taken only when req_pronto=1.
- req_escrita  in  1  1=store, 0=load.
- req_tamanho  in  2  00=byte, 01=halfword, 10=word, 11=reserved (treated as misaligned).
- req_sinal  in  1  loads only: 1=sign-extend, 0=zero-extend.
- req_endereco  in  ADDR_WIDTH  byte address.
- req_dados  in  32  store data; right-justified for byte/half.
- req_pronto  out  1  unit idle, can accept.
- resp_valido  out  1  one-cycle pulse: resp_dados valid (loads only).
- resp_dados  out  32  extended load result; holds until next load response.
- erro_alinhamento  out  1  one-cycle pulse: request rejected.
- mem_endereco  out  ADDR_WIDTH  word address = req_endereco[ADDR_WIDTH-1:2].
- mem_LeMem  out  1  read strobe.
- mem_EscreveMem  out  1  write strobe.
- mem_Dados_escrita  out  32  write data.
- mem_Dados_leitura  in  32  memory read data; valid the cycle after mem_LeMem is high.

Behaviour:
- Reset (async, immediate): state=OCIOSO. req_pronto=1. resp_valido=0, erro_alinhamento=0. mem_LeMem=0, mem_EscreveMem=0. mem_endereco=0, mem_Dados_escrita=0, resp_dados=0.
- All outputs are registered. Byte lanes are little-endian: offset k=addr[1:0] selects bits [8k+7:8k]. Halfword offset 0 selects [15:0]; offset 2 selects [31:16].
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00; tamanho=11 is always an error. On error: erro_alinhamento pulses in the next cycle, there is no memory access, the state stays OCIOSO, and req_pronto stays 1.
- FSM states: OCIOSO, LER, CAPTURA, ESCREVER.
- OCIOSO: req_pronto=1. On valid, aligned req_valido, latch address, size, sign flag and data.
  - Word store -> ESCREVER.
  - Any load, or byte/half store -> LER.
- LER: mem_LeMem=1 with mem_endereco valid. -> CAPTURA.
- CAPTURA: mem_LeMem=0; sample mem_Dados_leitura.
  - Load: extract lane, extend, register into resp_dados; resp_valido=1 in the following cycle. -> OCIOSO.
  - Sub-word store: replace only the addressed lane(s) with req_dados[7:0] or [15:0], keep other bytes; register into mem_Dados_escrita. -> ESCREVER.
- ESCREVER: mem_EscreveMem=1 for exactly one cycle with address and data stable for that whole cycle. -> OCIOSO.
- Latency, with acceptance at cycle 0:
  - Word store: write strobe in cycle 1; req_pronto in cycle 2.
  - Load: mem_LeMem in cycle 1; resp_valido in cycle 3, which coincides with req_pronto=1, so back-to-back acceptance in cycle 3 is allowed.
  - Sub-word store: write strobe in cycle 3; req_pronto in cycle 4.
- req_pronto=0 in LER, CAPTURA and ESCREVER. req_valido in those states is ignored; the requester holds it.
- mem_LeMem and mem_EscreveMem are never high in the same cycle.
- Reset asserted mid-operation: return to OCIOSO at once and drop all strobes. A sub-word store reset before ESCREVER leaves memory unmodified. No resp_valido is issued for the aborted request.

Optional Feature:
- Macro: LS_CONTADORES_EN.
- Defined: adds outputs cont_leituras[31:0] and cont_escritas[31:0].
  - Counts increment in the cycle mem_LeMem or mem_EscreveMem is high, respectively. An RMW store counts one read and one write.
  - Counters wrap from 0xFFFFFFFF to 0 and are cleared by reset_n.
- Undefined: both ports still exist and are tied to 0; no counter flops are synthesised.

Test Plan:
- Word store 0xDEADBEEF to addr 0x10, then word load from 0x10 -> mem_EscreveMem in cycle 1 with mem_endereco=4; load gives resp_valido 3 cycles after acceptance with resp_dados=0xDEADBEEF.
- Memory word at 0x20 = 0x11223344; byte store 0xAA to 0x22 -> LER, CAPTURA, then ESCREVER with mem_Dados_escrita=0x11AA3344; the whole store takes 4 cycles.
- Word 0x8000F0FF at 0x30: signed byte load from 0x30 -> 0xFFFFFFFF; unsigned byte load -> 0x000000FF; signed half load from 0x32 -> 0xFFFF8000.
- Half store to 0x41, word load from 0x42, and tamanho=11 -> each gives an erro_alinhamento pulse, with no mem_LeMem/mem_EscreveMem activity and req_pronto constantly 1.
- Pull reset_n low during CAPTURA of a byte store -> strobes drop at once with no write issued; the target word is unchanged on read-back after reset.
- With LS_CONTADORES_EN defined: 2 loads, 1 word store, 1 byte store -> cont_leituras=3, cont_escritas=2. Without the macro, both counters read 0.
